aha_prog_clock_divider: RTL and testbench
=========================================

AHA_PROG_CLOCK_DIVIDER -- requirements
Module: aha_prog_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 6: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 6: divide-code width; code D selects ratio N = D+1, range 1..2^DIV_W.
REQ-003 SHALL have derived localparam CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have ports: CLK_IN  in  1  sole clock; RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: CH_EN  in  NUM_CH  per-channel run enable (level); SYNC  in  1  phase-realign pulse.
REQ-006 SHALL have ports: CFG_VALID  in  1; CFG_READY  out  1; CFG_CH  in  CH_W; CFG_DIV  in  DIV_W  ratio-update request.
REQ-007 SHALL have ports: CLK_OUT  out  NUM_CH  divided clocks; CLK_EN  out  NUM_CH  one-cycle enable pulses at CLK_IN rate.
REQ-008 SHALL have ports: CH_ACTIVE  out  NUM_CH  channel running; CUR_DIV  out  NUM_CH*DIV_W  applied codes, channel c at bits [c*DIV_W +: DIV_W].

Function
REQ-009 SHALL run one counter per channel, cnt 0..N-1, incrementing each CLK_IN cycle and wrapping N-1 -> 0.
REQ-010 SHALL drive CLK_EN[c] high exactly in cycles where cnt==N-1; for N=1, constantly high while active.
REQ-011 SHALL drive CLK_OUT[c] high when cnt < ceil(N/2), else low; for N=1, constantly high while active; all outputs from flops, glitch-free.
REQ-012 SHALL accept a config when CFG_VALID && CFG_READY; CFG_READY = !pending[CFG_CH] (combinational).
REQ-013 SHALL hold an accepted code as pending and apply it only at the channel's wrap (cnt==N-1), so new N takes effect from cnt=0 next cycle; pending clears then.
REQ-014 SHALL, when a config is accepted in the wrap cycle itself, defer it to the following wrap.
REQ-015 SHALL accept and silently drop configs with CFG_CH >= NUM_CH (CFG_READY=1).
REQ-016 SHALL, on CH_EN[c] falling, keep running until the next wrap, then hold cnt=0, CLK_OUT=0, CLK_EN=0, CH_ACTIVE=0.
REQ-017 SHALL, while a channel is inactive, apply pending codes the cycle after acceptance.
REQ-018 SHALL, on CH_EN[c] rising on an inactive channel, set CH_ACTIVE next cycle and start from cnt=0.
REQ-019 SHALL, on SYNC high, force cnt=0 next cycle on all active channels and apply all pending codes (may truncate the current period).
REQ-020 SHALL prioritise RESET > SYNC > wrap > count.
REQ-021 SHALL update CUR_DIV in the same cycle the new code takes effect.

Reset
REQ-022 SHALL assert reset asynchronously and release through an internal 2-flop synchroniser on CLK_IN (async set, sync release).
REQ-023 SHALL reset: cnt=0, pending=0, CLK_OUT=0, CLK_EN=0, CH_ACTIVE=0, CUR_DIV[c]=2^c-1 (ratio 2^c, clamped to 2^DIV_W).
REQ-024 SHALL begin counting on enabled channels the first cycle after synchronised release; reset mid-period discards pending updates.

Structure
REQ-025 SHALL place the default parameters and reset-ratio function in shared package aha_clk_div_pkg.
REQ-026 SHALL implement one sub-module, aha_clk_div_channel (counter, pending register, enable/stop FSM IDLE/RUN/STOPPING), instantiated NUM_CH times.

Verification
REQ-027 Reset, all CH_EN=1 -> channel 3 CLK_EN pulses every 8 cycles, CLK_OUT 4 high/4 low; channel 0 CLK_EN constant 1.
REQ-028 Config ch1 CFG_DIV=4 mid-period -> old period (2) completes, then CLK_EN every 5 cycles, CLK_OUT 3 high/2 low, CUR_DIV updates at switch.
REQ-029 Second config to ch1 while pending -> CFG_READY=0; first value applied, second accepted next cycle after apply.
REQ-030 CH_EN[2] drop at cnt=1 (N=4) -> runs to cnt=3, then outputs 0, CH_ACTIVE 0; re-enable -> CLK_EN after 4 cycles.
REQ-031 SYNC pulse with channels at mixed phases -> all cnt=0 next cycle; all CLK_EN coincide at least-common periods.
REQ-032 RESET asserted mid-period with pending update -> outputs 0 immediately, CUR_DIV back to reset codes, pending discarded.

Source files
------------

// File: rtl/aha_clk_div_pkg.sv
// Shared definitions for the programmable clock divider: default sizing,
// channel FSM encoding and the per-channel reset divide code.
package aha_clk_div_pkg;

   localparam int DEF_NUM_CH = 6;
   localparam int DEF_DIV_W  = 6;

   typedef enum logic [1:0] {
      CH_IDLE     = 2'd0,
      CH_RUN      = 2'd1,
      CH_STOPPING = 2'd2
   } ch_state_e;

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Channel c comes out of reset dividing by 2^c, saturating at 2^div_w.
   function automatic int reset_code(input int ch, input int div_w);
      if (ch >= div_w) return (1 << div_w) - 1;
      return (1 << ch) - 1;
   endfunction

endpackage

// File: rtl/aha_clk_div_channel.sv
// One divider channel: wrap counter, pending ratio register and the
// IDLE/RUN/STOPPING enable FSM. All outputs are registered.
module aha_clk_div_channel
   import aha_clk_div_pkg::*;
#(
   parameter int               DIV_W    = DEF_DIV_W,
   parameter logic [DIV_W-1:0] RST_CODE = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             cfg_we_i,
   input  logic [DIV_W-1:0] cfg_div_i,
   output logic             pend_o,
   output logic             clk_out_o,
   output logic             clk_en_o,
   output logic             active_o,
   output logic [DIV_W-1:0] cur_div_o,
   output ch_state_e        state_o
);

   ch_state_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] pdiv_q, pdiv_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             clk_en_q, clk_en_d;
   logic             active_q, active_d;
   logic             wrap;
   logic             apply;

   assign wrap = (cnt_q == div_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      pdiv_d  = pdiv_q;
      apply   = 1'b0;
      case (state_q)
         CH_IDLE: begin
            apply = pend_q;
            cnt_d = '0;
            if (en_i) state_d = CH_RUN;
         end
         CH_RUN, CH_STOPPING: begin
            // A dropped enable only takes effect at a natural wrap; SYNC never stops a channel.
            if (sync_i) begin
               cnt_d   = '0;
               apply   = pend_q;
               state_d = en_i ? CH_RUN : CH_STOPPING;
            end else if (wrap) begin
               cnt_d   = '0;
               apply   = pend_q;
               state_d = en_i ? CH_RUN : CH_IDLE;
            end else begin
               cnt_d   = cnt_q + DIV_W'(1);
               state_d = en_i ? CH_RUN : CH_STOPPING;
            end
         end
         default: state_d = CH_IDLE;
      endcase

      if (apply) begin
         div_d  = pdiv_q;
         pend_d = 1'b0;
      end
      if (cfg_we_i) begin
         pend_d = 1'b1;
         pdiv_d = cfg_div_i;
      end

      // Outputs are decoded from next-state so the flops line up with cnt.
      active_d  = (state_d != CH_IDLE);
      clk_en_d  = active_d && (cnt_d == div_d);
      clk_out_d = active_d && (cnt_d <= (div_d >> 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= CH_IDLE;
         cnt_q     <= '0;
         div_q     <= RST_CODE;
         pdiv_q    <= '0;
         pend_q    <= 1'b0;
         clk_out_q <= 1'b0;
         clk_en_q  <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         pdiv_q    <= pdiv_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         clk_en_q  <= clk_en_d;
         active_q  <= active_d;
      end
   end

   assign pend_o    = pend_q;
   assign clk_out_o = clk_out_q;
   assign clk_en_o  = clk_en_q;
   assign active_o  = active_q;
   assign cur_div_o = div_q;
   assign state_o   = state_q;

endmodule

// File: rtl/aha_prog_clock_divider.sv
// Multi-channel programmable clock divider with per-channel ratio updates
// applied at period boundaries, enable/stop control and global phase SYNC.
module aha_prog_clock_divider
   import aha_clk_div_pkg::*;
#(
   parameter  int NUM_CH = DEF_NUM_CH,
   parameter  int DIV_W  = DEF_DIV_W,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic                    CLK_IN,
   input  logic                    RESET,
   input  logic [NUM_CH-1:0]       CH_EN,
   input  logic                    SYNC,
   input  logic                    CFG_VALID,
   output logic                    CFG_READY,
   input  logic [CH_W-1:0]         CFG_CH,
   input  logic [DIV_W-1:0]        CFG_DIV,
   output logic [NUM_CH-1:0]       CLK_OUT,
   output logic [NUM_CH-1:0]       CLK_EN,
   output logic [NUM_CH-1:0]       CH_ACTIVE,
   output logic [NUM_CH*DIV_W-1:0] CUR_DIV,
   output logic [2*NUM_CH-1:0]     DBG_STATE
);

   logic [1:0]            rst_sync_q;
   logic                  rst_int;
   logic [NUM_CH-1:0]     pend;
   logic [NUM_CH-1:0]     cfg_we;
   logic [(1<<CH_W)-1:0]  pend_ext;

   // Reset asserts immediately, releases two CLK_IN edges later.
   always_ff @(posedge CLK_IN or posedge RESET) begin
      if (RESET) rst_sync_q <= 2'b11;
      else       rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   // Out-of-range channel numbers read as "not pending" so they are accepted and dropped.
   always_comb begin
      pend_ext             = '0;
      pend_ext[NUM_CH-1:0] = pend;
   end
   assign CFG_READY = !pend_ext[CFG_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ch_state_e st;

      assign cfg_we[c] = CFG_VALID && (CFG_CH == CH_W'(c)) && !pend[c];

      aha_clk_div_channel #(
         .DIV_W    (DIV_W),
         .RST_CODE (DIV_W'(reset_code(c, DIV_W)))
      ) u_ch (
         .clk_i     (CLK_IN),
         .rst_i     (rst_int),
         .en_i      (CH_EN[c]),
         .sync_i    (SYNC),
         .cfg_we_i  (cfg_we[c]),
         .cfg_div_i (CFG_DIV),
         .pend_o    (pend[c]),
         .clk_out_o (CLK_OUT[c]),
         .clk_en_o  (CLK_EN[c]),
         .active_o  (CH_ACTIVE[c]),
         .cur_div_o (CUR_DIV[c*DIV_W +: DIV_W]),
         .state_o   (st)
      );

      assign DBG_STATE[2*c +: 2] = st;
   end

endmodule

// File: tb/tb_aha_prog_clock_divider.sv
// Randomized and directed bench for aha_prog_clock_divider, checked against
// a ratio/phase reference model of each channel.
module tb_aha_prog_clock_divider;
   import aha_clk_div_pkg::*;

   localparam int NUM_CH = 6;
   localparam int DIV_W  = 6;
   localparam int CH_W   = 3;
   localparam int SW     = NUM_CH*DIV_W + 3*NUM_CH + 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       ch_en;
   logic                    sync;
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [CH_W-1:0]         cfg_ch;
   logic [DIV_W-1:0]        cfg_div;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       clk_en;
   logic [NUM_CH-1:0]       ch_active;
   logic [NUM_CH*DIV_W-1:0] cur_div;
   logic [2*NUM_CH-1:0]     dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: ratio N, phase count, activity and pending ratio per channel
   int m_cnt  [NUM_CH];
   int m_n    [NUM_CH];
   int m_pn   [NUM_CH];
   bit m_act  [NUM_CH];
   bit m_pend [NUM_CH];
   int m_hold;

   logic [SW-1:0] exp_q[$];

   int en3_cnt, en0_cnt, out3_cnt, en1_cnt, out1_cnt;

   aha_prog_clock_divider dut (
      .CLK_IN    (clk),
      .RESET     (rst),
      .CH_EN     (ch_en),
      .SYNC      (sync),
      .CFG_VALID (cfg_valid),
      .CFG_READY (cfg_ready),
      .CFG_CH    (cfg_ch),
      .CFG_DIV   (cfg_div),
      .CLK_OUT   (clk_out),
      .CLK_EN    (clk_en),
      .CH_ACTIVE (ch_active),
      .CUR_DIV   (cur_div),
      .DBG_STATE (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rst_ratio(input int c);
      return (c >= DIV_W) ? (1 << DIV_W) : (1 << c);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c]  = 0;
         m_n[c]    = rst_ratio(c);
         m_pn[c]   = 1;
         m_act[c]  = 1'b0;
         m_pend[c] = 1'b0;
      end
      m_hold = 2;
   endtask

   function automatic bit model_ready();
      return (int'(cfg_ch) >= NUM_CH) ? 1'b1 : !m_pend[cfg_ch];
   endfunction

   task automatic model_step();
      bit acc [NUM_CH];
      if (rst) begin
         model_reset();
         return;
      end
      if (m_hold > 0) begin
         m_hold--;
         return;
      end
      for (int c = 0; c < NUM_CH; c++)
         acc[c] = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_act[c]) begin
            if (sync || (m_cnt[c] == m_n[c] - 1)) begin
               if (!sync && !ch_en[c]) m_act[c] = 1'b0;
               m_cnt[c] = 0;
               if (m_pend[c]) begin
                  m_n[c]    = m_pn[c];
                  m_pend[c] = 1'b0;
               end
            end else begin
               m_cnt[c]++;
            end
         end else begin
            if (m_pend[c]) begin
               m_n[c]    = m_pn[c];
               m_pend[c] = 1'b0;
            end
            if (ch_en[c]) begin
               m_act[c] = 1'b1;
               m_cnt[c] = 0;
            end
         end
         if (acc[c]) begin
            m_pend[c] = 1'b1;
            m_pn[c]   = int'(cfg_div) + 1;
         end
      end
   endtask

   function automatic logic [SW-1:0] model_expect();
      logic [NUM_CH*DIV_W-1:0] e_cur;
      logic [NUM_CH-1:0]       e_act, e_out, e_en;
      for (int c = 0; c < NUM_CH; c++) begin
         e_act[c] = m_act[c];
         e_en[c]  = m_act[c] && (m_cnt[c] == m_n[c] - 1);
         e_out[c] = m_act[c] && (m_cnt[c] < (m_n[c] + 1) / 2);
         e_cur[c*DIV_W +: DIV_W] = DIV_W'(m_n[c] - 1);
      end
      return {e_cur, e_act, e_out, e_en, model_ready()};
   endfunction

   // one CLK_IN cycle: check at negedge, advance model at posedge
   task automatic cycle();
      logic [SW-1:0]           e;
      logic [NUM_CH*DIV_W-1:0] e_cur;
      logic [NUM_CH-1:0]       e_act, e_out, e_en, busy;
      logic                    e_rdy;
      @(negedge clk);
      exp_q.push_back(model_expect());
      e = exp_q.pop_front();
      {e_cur, e_act, e_out, e_en, e_rdy} = e;
      for (int c = 0; c < NUM_CH; c++)
         busy[c] = (dbg_state[2*c +: 2] != CH_IDLE);
      check_eq("clk_en",    64'(clk_en),    64'(e_en));
      check_eq("clk_out",   64'(clk_out),   64'(e_out));
      check_eq("ch_active", 64'(ch_active), 64'(e_act));
      check_eq("cur_div",   64'(cur_div),   64'(e_cur));
      check_eq("cfg_ready", 64'(cfg_ready), 64'(e_rdy));
      check_eq("dbg_state", 64'(busy),      64'(e_act));
      en0_cnt  += int'(clk_en[0]);
      en3_cnt  += int'(clk_en[3]);
      out3_cnt += int'(clk_out[3]);
      en1_cnt  += int'(clk_en[1]);
      out1_cnt += int'(clk_out[1]);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_cfg(input int ch, input int div, output int waited);
      bit r;
      bit ok;
      ok        = 1'b0;
      waited    = 0;
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(div);
      for (int i = 0; i < 64; i++) begin
         r = model_ready();
         cycle();
         if (r) begin
            ok = 1'b1;
            break;
         end
         waited++;
      end
      cfg_valid = 1'b0;
      if (!ok) check_eq("cfg_timeout", 64'(ok), 64'(1));
   endtask

   task automatic wait_phase(input int c, input int cnt);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_act[c] && m_cnt[c] == cnt) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
      if (!ok) check_eq("phase_timeout", 64'(ok), 64'(1));
   endtask

   task automatic set_reset(input logic v);
      rst = v;
      if (v) model_reset();
   endtask

   initial begin
      logic [NUM_CH*DIV_W-1:0] rst_vec;
      int  waited;
      bit  ok;

      for (int c = 0; c < NUM_CH; c++) rst_vec[c*DIV_W +: DIV_W] = DIV_W'(rst_ratio(c) - 1);

      ch_en     = '0;
      sync      = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      set_reset(1'b1);
      run(3);
      check_eq("reset_cur_div", 64'(cur_div), 64'(rst_vec));
      check_eq("reset_clk_out", 64'(clk_out), 64'(0));
      check_eq("reset_active",  64'(ch_active), 64'(0));

      // all channels running from reset ratios
      ch_en = '1;
      set_reset(1'b0);
      run(10);
      en0_cnt = 0; en3_cnt = 0; out3_cnt = 0;
      run(32);
      check_eq("ch3_pulses", 64'(en3_cnt), 64'(4));
      check_eq("ch3_high",   64'(out3_cnt), 64'(16));
      check_eq("ch0_pulses", 64'(en0_cnt), 64'(32));

      // ch1 ratio change to 5 mid-period
      run(1);
      send_cfg(1, 4, waited);
      check_eq("ch1_first_wait", 64'(waited), 64'(0));
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_n[1] == 5 && !m_pend[1]) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
      check_eq("ch1_applied", 64'(ok), 64'(1));
      en1_cnt = 0; out1_cnt = 0;
      run(30);
      check_eq("ch1_pulses", 64'(en1_cnt), 64'(6));
      check_eq("ch1_high",   64'(out1_cnt), 64'(18));

      // back-to-back configs: the second waits for the first to apply
      send_cfg(1, 2, waited);
      send_cfg(1, 6, waited);
      check_eq("ch1_second_waited", 64'(waited > 0), 64'(1));
      check_eq("ch1_cur_at_accept", 64'(cur_div[1*DIV_W +: DIV_W]), 64'(2));
      run(20);

      // ch2 stop at cnt=1 (N=4), then restart
      wait_phase(2, 1);
      ch_en[2] = 1'b0;
      run(6);
      check_eq("ch2_stopped", 64'(ch_active[2]), 64'(0));
      ch_en[2] = 1'b1;
      run(3);
      check_eq("ch2_restart_early", 64'(clk_en[2]), 64'(0));
      run(1);
      check_eq("ch2_restart_pulse", 64'(clk_en[2]), 64'(1));

      // SYNC realigns every active channel to cnt=0
      run(3);
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      check_eq("sync_out", 64'(clk_out), 64'(6'h3f));
      check_eq("sync_en",  64'(clk_en),  64'(6'h01));
      run(60);

      // out-of-range channels are accepted and dropped
      send_cfg(6, 5, waited);
      check_eq("oob6_wait", 64'(waited), 64'(0));
      send_cfg(7, 3, waited);
      check_eq("oob7_wait", 64'(waited), 64'(0));
      run(10);
      check_eq("oob_no_effect", 64'(cur_div), 64'({6'd31, 6'd15, 6'd7, 6'd3, 6'd6, 6'd0}));

      // reset with a pending update on ch4
      run(5);
      send_cfg(4, 2, waited);
      set_reset(1'b1);
      cycle();
      check_eq("rst_mid_cur_div", 64'(cur_div), 64'(rst_vec));
      check_eq("rst_mid_clk_out", 64'(clk_out), 64'(0));
      check_eq("rst_mid_clk_en",  64'(clk_en), 64'(0));
      run(2);
      set_reset(1'b0);
      run(40);
      check_eq("rst_pending_dropped", 64'(cur_div[4*DIV_W +: DIV_W]), 64'(15));

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3) ch_en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
         sync      = ($urandom_range(0, 49) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = CH_W'($urandom_range(0, 7));
         cfg_div   = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 63))
                                                 : DIV_W'($urandom_range(0, 7));
         set_reset($urandom_range(0, 399) == 0);
         cycle();
      end
      sync      = 1'b0;
      cfg_valid = 1'b0;
      set_reset(1'b0);
      run(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
